// File: rtl/hazard_detection_unit.sv
// ID-stage stall decision: load-use, branch-in-ID, MDU scoreboard RAW/WAW and MDU capacity.
// Optional saturating perf counters when HAZARD_PERF_CNT_EN is defined.
module hazard_detection_unit #(
  parameter int MDU_MAX_PENDING = 2,
  parameter int CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_address_id_i,
  input  logic [4:0] rs2_address_id_i,
  input  logic [4:0] rs3_address_id_i,
  input  logic [2:0] rs_used_id_i,
  input  logic [4:0] rd_address_id_i,
  input  logic       rd_we_id_i,
  input  logic       branch_id_i,
  input  logic       mdu_op_id_i,
  input  logic       rd_we_ex_i,
  input  logic       mem_to_reg_ex_i,
  input  logic [4:0] rd_address_ex_i,
  input  logic       rd_we_mem_i,
  input  logic       mem_to_reg_mem_i,
  input  logic [4:0] rd_address_mem_i,
  input  logic       mdu_issue_i,
  input  logic [4:0] mdu_issue_rd_i,
  input  logic       mdu_wb_i,
  input  logic [4:0] mdu_wb_rd_i,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       id_ex_flush_o,
  output logic [2:0] mdu_pending_o,
  output logic       err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] lu_stalls_o
`endif
);

  if (MDU_MAX_PENDING < 1 || MDU_MAX_PENDING > 4 || CNT_W < 1) begin : g_bad_param
    $error("hazard_detection_unit: parameter out of range");
  end

  localparam logic [2:0] MaxPend = 3'(MDU_MAX_PENDING);

  logic [31:0] busy_q;
  logic [2:0]  pending_q;
  logic        err_q;

  logic [4:0] rs_addr [3];
  logic [2:0] used;
  logic       ld_ex;
  logic       lu, br, sb, waw, st, stall;

  assign rs_addr[0] = rs1_address_id_i;
  assign rs_addr[1] = rs2_address_id_i;
  assign rs_addr[2] = rs3_address_id_i;

  assign ld_ex = mem_to_reg_ex_i && rd_we_ex_i && (rd_address_ex_i != 5'd0);

  // Branches resolve in ID, so only rs1/rs2 see the stricter EX/MEM producer rules.
  always_comb begin
    used = 3'b000;
    lu   = 1'b0;
    br   = 1'b0;
    sb   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      used[i] = rs_used_id_i[i] && (rs_addr[i] != 5'd0);
      if (used[i]) begin
        if (ld_ex && (rs_addr[i] == rd_address_ex_i))
          lu = 1'b1;
        if (branch_id_i && (i < 2) &&
            ((rd_we_ex_i && (rs_addr[i] == rd_address_ex_i)) ||
             (rd_we_mem_i && mem_to_reg_mem_i && (rs_addr[i] == rd_address_mem_i))))
          br = 1'b1;
        if (busy_q[rs_addr[i]] || (mdu_issue_i && (mdu_issue_rd_i == rs_addr[i])))
          sb = 1'b1;
      end
    end
  end

  assign waw   = rd_we_id_i && (rd_address_id_i != 5'd0) && busy_q[rd_address_id_i];
  assign st    = mdu_op_id_i && (pending_q == MaxPend);
  assign stall = lu | br | sb | waw | st;

  assign pc_en_o       = !stall;
  assign if_id_en_o    = !stall;
  assign id_ex_flush_o = stall;
  assign mdu_pending_o = pending_q;
  assign err_o         = err_q;

  // The later set overrides a same-register clear, so issue wins on a shared rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (mdu_wb_i && (mdu_wb_rd_i != 5'd0))
        busy_q[mdu_wb_rd_i] <= 1'b0;
      if (mdu_issue_i && (mdu_issue_rd_i != 5'd0))
        busy_q[mdu_issue_rd_i] <= 1'b1;
      case ({mdu_issue_i, mdu_wb_i})
        2'b10: begin
          if (pending_q == MaxPend) err_q <= 1'b1;
          else                      pending_q <= pending_q + 3'd1;
        end
        2'b01: begin
          if (pending_q == 3'd0) err_q <= 1'b1;
          else                   pending_q <= pending_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= '0;
      lu_stalls_o    <= '0;
    end else begin
      if (stall && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + 1'b1;
      if (lu && (lu_stalls_o != '1))       lu_stalls_o    <= lu_stalls_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed vector table, multi-cycle
// scoreboard sequences, and randomized traffic against a behavioural model.
module tb_hazard_detection_unit;
  localparam int MAX = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_address_id_i, rs2_address_id_i, rs3_address_id_i;
  logic [2:0] rs_used_id_i;
  logic [4:0] rd_address_id_i;
  logic       rd_we_id_i, branch_id_i, mdu_op_id_i;
  logic       rd_we_ex_i, mem_to_reg_ex_i;
  logic [4:0] rd_address_ex_i;
  logic       rd_we_mem_i, mem_to_reg_mem_i;
  logic [4:0] rd_address_mem_i;
  logic       mdu_issue_i;
  logic [4:0] mdu_issue_rd_i;
  logic       mdu_wb_i;
  logic [4:0] mdu_wb_rd_i;
  logic       pc_en_o, if_id_en_o, id_ex_flush_o, err_o;
  logic [2:0] mdu_pending_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_o, lu_stalls_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.MDU_MAX_PENDING(MAX), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_address_id_i(rs1_address_id_i), .rs2_address_id_i(rs2_address_id_i),
    .rs3_address_id_i(rs3_address_id_i), .rs_used_id_i(rs_used_id_i),
    .rd_address_id_i(rd_address_id_i), .rd_we_id_i(rd_we_id_i),
    .branch_id_i(branch_id_i), .mdu_op_id_i(mdu_op_id_i),
    .rd_we_ex_i(rd_we_ex_i), .mem_to_reg_ex_i(mem_to_reg_ex_i),
    .rd_address_ex_i(rd_address_ex_i),
    .rd_we_mem_i(rd_we_mem_i), .mem_to_reg_mem_i(mem_to_reg_mem_i),
    .rd_address_mem_i(rd_address_mem_i),
    .mdu_issue_i(mdu_issue_i), .mdu_issue_rd_i(mdu_issue_rd_i),
    .mdu_wb_i(mdu_wb_i), .mdu_wb_rd_i(mdu_wb_rd_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .id_ex_flush_o(id_ex_flush_o),
    .mdu_pending_o(mdu_pending_o), .err_o(err_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles_o(stall_cycles_o), .lu_stalls_o(lu_stalls_o)
`endif
  );

  typedef struct {
    logic [4:0] rs1, rs2, rs3;
    logic [2:0] used;
    logic [4:0] rd;
    logic       rd_we, branch, mdu_op;
    logic       ex_we, ex_ld;
    logic [4:0] ex_rd;
    logic       mem_we, mem_ld;
    logic [4:0] mem_rd;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [13];

  task automatic clearInputs();
    rs1_address_id_i = '0; rs2_address_id_i = '0; rs3_address_id_i = '0;
    rs_used_id_i = '0; rd_address_id_i = '0; rd_we_id_i = 0;
    branch_id_i = 0; mdu_op_id_i = 0;
    rd_we_ex_i = 0; mem_to_reg_ex_i = 0; rd_address_ex_i = '0;
    rd_we_mem_i = 0; mem_to_reg_mem_i = 0; rd_address_mem_i = '0;
    mdu_issue_i = 0; mdu_issue_rd_i = '0; mdu_wb_i = 0; mdu_wb_rd_i = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rs1_address_id_i = v.rs1; rs2_address_id_i = v.rs2; rs3_address_id_i = v.rs3;
    rs_used_id_i = v.used; rd_address_id_i = v.rd; rd_we_id_i = v.rd_we;
    branch_id_i = v.branch; mdu_op_id_i = v.mdu_op;
    rd_we_ex_i = v.ex_we; mem_to_reg_ex_i = v.ex_ld; rd_address_ex_i = v.ex_rd;
    rd_we_mem_i = v.mem_we; mem_to_reg_mem_i = v.mem_ld; rd_address_mem_i = v.mem_rd;
    mdu_issue_i = 0; mdu_wb_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic exp_stall,
                             input int exp_pend, input logic exp_err);
    total++;
    if ({pc_en_o, if_id_en_o, id_ex_flush_o} !== {~exp_stall, ~exp_stall, exp_stall}) begin
      bad++;
      $display("[TB] FAIL %s ctl pc/ifid/flush got=%b%b%b want=%b%b%b", name,
               pc_en_o, if_id_en_o, id_ex_flush_o, ~exp_stall, ~exp_stall, exp_stall);
    end
    total++;
    if (mdu_pending_o !== 3'(exp_pend)) begin
      bad++;
      $display("[TB] FAIL %s pending got=%0d want=%0d", name, mdu_pending_o, exp_pend);
    end
    total++;
    if (err_o !== exp_err) begin
      bad++;
      $display("[TB] FAIL %s err got=%b want=%b", name, err_o, exp_err);
    end
  endtask

  // Behavioural model state for the random phase
  bit busy_m [32];
  int cnt_m;
  bit err_m;

  initial begin
    vecs[0]  = '{rs1:5, used:3'b001, ex_we:1, ex_ld:1, ex_rd:5, exp_stall:1, default:0};
    vecs[1]  = '{rs1:0, used:3'b001, ex_we:1, ex_ld:1, ex_rd:0, exp_stall:0, default:0};
    vecs[2]  = '{rs1:5, used:3'b000, ex_we:1, ex_ld:1, ex_rd:5, exp_stall:0, default:0};
    vecs[3]  = '{rs3:5, used:3'b100, ex_we:1, ex_ld:1, ex_rd:5, exp_stall:1, default:0};
    vecs[4]  = '{rs1:5, used:3'b001, ex_we:1, ex_ld:0, ex_rd:5, exp_stall:0, default:0};
    vecs[5]  = '{rs2:7, used:3'b010, branch:1, ex_we:1, ex_rd:7, exp_stall:1, default:0};
    vecs[6]  = '{rs2:7, used:3'b010, branch:1, mem_we:1, mem_ld:0, mem_rd:7, exp_stall:0, default:0};
    vecs[7]  = '{rs2:7, used:3'b010, branch:1, mem_we:1, mem_ld:1, mem_rd:7, exp_stall:1, default:0};
    vecs[8]  = '{rs3:7, used:3'b100, branch:1, ex_we:1, ex_rd:7, exp_stall:0, default:0};
    vecs[9]  = '{rs2:7, used:3'b010, branch:1, ex_we:0, ex_rd:7, exp_stall:0, default:0};
    vecs[10] = '{rs1:7, used:3'b001, mem_we:1, mem_ld:1, mem_rd:7, exp_stall:0, default:0};
    vecs[11] = '{mdu_op:1, rd:9, rd_we:1, exp_stall:0, default:0};
    vecs[12] = '{rs1:5, used:3'b001, ex_we:0, ex_ld:1, ex_rd:5, exp_stall:0, default:0};

    clearInputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1 checkOutput("reset", 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      #1 checkOutput($sformatf("vec%0d", i), vecs[i].exp_stall, 0, 0);
      tick();
    end

    // Scoreboard RAW through issue bypass until after writeback
    clearInputs();
    mdu_issue_i = 1; mdu_issue_rd_i = 10; rs1_address_id_i = 10; rs_used_id_i = 3'b001;
    #1 checkOutput("sb_bypass", 1, 0, 0);
    tick(); mdu_issue_i = 0;
    #1 checkOutput("sb_busy", 1, 1, 0);
    tick();
    #1 checkOutput("sb_hold", 1, 1, 0);
    mdu_wb_i = 1; mdu_wb_rd_i = 10;
    #1 checkOutput("sb_wb_cycle", 1, 1, 0);
    tick(); mdu_wb_i = 0;
    #1 checkOutput("sb_release", 0, 0, 0);

    // Structural full, WAW on busy destinations
    clearInputs();
    mdu_issue_i = 1; mdu_issue_rd_i = 3;
    tick(); mdu_issue_rd_i = 4;
    tick(); mdu_issue_i = 0; mdu_op_id_i = 1;
    #1 checkOutput("full_stall", 1, 2, 0);
    mdu_op_id_i = 0; rd_we_id_i = 1; rd_address_id_i = 4;
    #1 checkOutput("waw_busy", 1, 2, 0);
    rd_address_id_i = 5;
    #1 checkOutput("waw_free", 0, 2, 0);
    rd_we_id_i = 0; mdu_op_id_i = 1; mdu_wb_i = 1; mdu_wb_rd_i = 3;
    #1 checkOutput("full_wb_cycle", 1, 2, 0);
    tick(); mdu_wb_i = 0;
    #1 checkOutput("full_release", 0, 1, 0);
    mdu_op_id_i = 0; mdu_wb_i = 1; mdu_wb_rd_i = 4;
    tick(); mdu_wb_i = 0;
    #1 checkOutput("drain", 0, 0, 0);

    // Simultaneous issue/wb on same rd, then underflow
    clearInputs();
    mdu_issue_i = 1; mdu_issue_rd_i = 8;
    tick();
    mdu_wb_i = 1; mdu_wb_rd_i = 8;
    tick(); mdu_issue_i = 0; mdu_wb_i = 0; rs1_address_id_i = 8; rs_used_id_i = 3'b001;
    #1 checkOutput("sim_iw", 1, 1, 0);
    mdu_wb_i = 1; mdu_wb_rd_i = 8;
    tick(); mdu_wb_i = 0;
    #1 checkOutput("sim_drain", 0, 0, 0);
    mdu_wb_i = 1; mdu_wb_rd_i = 9;
    tick(); mdu_wb_i = 0;
    #1 checkOutput("underflow", 0, 0, 1);
    tick(); tick();
    #1 checkOutput("err_sticky", 0, 0, 1);
    rst = 1; tick(); rst = 0;
    #1 checkOutput("err_clear", 0, 0, 0);

    // Overflow
    clearInputs();
    mdu_issue_i = 1; mdu_issue_rd_i = 1;
    tick(); mdu_issue_rd_i = 2;
    tick(); mdu_issue_rd_i = 5;
    tick(); mdu_issue_i = 0;
    #1 checkOutput("overflow", 0, 2, 1);

    // Reset in the middle of outstanding work
    rst = 1; tick(); rst = 0;
    mdu_issue_i = 1; mdu_issue_rd_i = 3;
    tick(); mdu_issue_rd_i = 4;
    tick(); mdu_issue_i = 0; rs1_address_id_i = 3; rs_used_id_i = 3'b001;
    #1 checkOutput("pre_reset", 1, 2, 0);
    rst = 1; tick(); rst = 0;
    #1 checkOutput("reset_mid", 0, 0, 0);

    // Randomized traffic against the model
    clearInputs();
    rst = 1; tick(); rst = 0;
    for (int r = 0; r < 32; r++) busy_m[r] = 0;
    cnt_m = 0; err_m = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit hz;
      int src [3];
      rst = ($urandom_range(0, 39) == 0);
      rs1_address_id_i = 5'($urandom_range(0, 7));
      rs2_address_id_i = 5'($urandom_range(0, 7));
      rs3_address_id_i = 5'($urandom_range(0, 7));
      rs_used_id_i = 3'($urandom);
      rd_address_id_i = 5'($urandom_range(0, 7));
      rd_we_id_i = 1'($urandom);
      branch_id_i = ($urandom_range(0, 3) == 0);
      mdu_op_id_i = ($urandom_range(0, 3) == 0);
      rd_we_ex_i = 1'($urandom); mem_to_reg_ex_i = 1'($urandom);
      rd_address_ex_i = 5'($urandom_range(0, 7));
      rd_we_mem_i = 1'($urandom); mem_to_reg_mem_i = 1'($urandom);
      rd_address_mem_i = 5'($urandom_range(0, 7));
      mdu_issue_i = ($urandom_range(0, 3) == 0);
      mdu_issue_rd_i = 5'($urandom_range(0, 7));
      mdu_wb_i = ($urandom_range(0, 3) == 0);
      mdu_wb_rd_i = 5'($urandom_range(0, 7));
      #1;
      src[0] = int'(rs1_address_id_i);
      src[1] = int'(rs2_address_id_i);
      src[2] = int'(rs3_address_id_i);
      hz = 0;
      for (int n = 0; n < 3; n++) begin
        if (rs_used_id_i[n] && src[n] != 0) begin
          if (rd_we_ex_i && mem_to_reg_ex_i && int'(rd_address_ex_i) == src[n]) hz = 1;
          if (branch_id_i && n < 2 &&
              ((rd_we_ex_i && int'(rd_address_ex_i) == src[n]) ||
               (rd_we_mem_i && mem_to_reg_mem_i && int'(rd_address_mem_i) == src[n]))) hz = 1;
          if (busy_m[src[n]] || (mdu_issue_i && int'(mdu_issue_rd_i) == src[n])) hz = 1;
        end
      end
      if (rd_we_id_i && rd_address_id_i != 0 && busy_m[rd_address_id_i]) hz = 1;
      if (mdu_op_id_i && cnt_m == MAX) hz = 1;
      checkOutput($sformatf("rand%0d", cyc), hz, cnt_m, err_m);

      if (rst) begin
        for (int r = 0; r < 32; r++) busy_m[r] = 0;
        cnt_m = 0; err_m = 0;
      end else begin
        if (mdu_wb_i && mdu_wb_rd_i != 0) busy_m[mdu_wb_rd_i] = 0;
        if (mdu_issue_i && mdu_issue_rd_i != 0) busy_m[mdu_issue_rd_i] = 1;
        if (mdu_issue_i && !mdu_wb_i) begin
          if (cnt_m == MAX) err_m = 1; else cnt_m = cnt_m + 1;
        end else if (mdu_wb_i && !mdu_issue_i) begin
          if (cnt_m == 0) err_m = 1; else cnt_m = cnt_m - 1;
        end
      end
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Decides when the RV32IM pipeline must stall because operand forwarding cannot supply a value in time. It is the stall-side counterpart to operand forwarding.
- Sits in ID. It compares ID source registers against producers in EX and MEM, and against a scoreboard of in-flight multi-cycle MDU (mul/div) results.
- Drives the PC/IF-ID hold and the ID/EX bubble.

Parameters:
- MDU_MAX_PENDING, 2: max outstanding MDU ops tracked; range 1..4.
- CNT_W, 32: width of perf counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs1_address_id_i, rs2_address_id_i, rs3_address_id_i  in  5 each  ID source addresses
- rs_used_id_i  in  3  per-source valid; bit0=rs1, bit1=rs2, bit2=rs3
- rd_address_id_i  in  5  ID destination
- rd_we_id_i  in  1  ID writes rd
- branch_id_i  in  1  ID holds a branch; it compares in ID
- mdu_op_id_i  in  1  ID holds an MDU op
- rd_we_ex_i, mem_to_reg_ex_i  in  1 each  EX write enable / EX is load
- rd_address_ex_i  in  5  EX destination
- rd_we_mem_i, mem_to_reg_mem_i  in  1 each  MEM write enable / MEM is load
- rd_address_mem_i  in  5  MEM destination
- mdu_issue_i  in  1  MDU op leaves EX this cycle
- mdu_issue_rd_i  in  5  its destination
- mdu_wb_i  in  1  MDU result written back this cycle
- mdu_wb_rd_i  in  5  its destination
- pc_en_o, if_id_en_o  out  1 each  0 = hold
- id_ex_flush_o  out  1  1 = insert bubble
- mdu_pending_o  out  3  outstanding MDU count
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at posedge clk): busy vector = 0, pending = 0, err_o = 0.
- Outputs during and after reset are combinational on cleared state: pc_en_o = 1, if_id_en_o = 1, id_ex_flush_o = 0 unless inputs cause a stall.
- "used(rsN)" means rs_used_id_i[N] && rsN != 0. Register x0 never causes a hazard.
- Stall reasons, all combinational, no extra latency:
  - LU (load-use): mem_to_reg_ex_i && rd_we_ex_i && rd_address_ex_i != 0 && it matches any used rs.
  - BR (branch): branch_id_i && used(rs1|rs2) matching one of:
    - EX with rd_we_ex_i (any EX writer)
    - MEM with rd_we_mem_i && mem_to_reg_mem_i (load data not forwardable to ID).
  - SB (scoreboard RAW): any used rs with busy[rs] = 1, or with mdu_issue_i && mdu_issue_rd_i == rs (set-bypass).
  - WAW: rd_we_id_i && rd_address_id_i != 0 && busy[rd_address_id_i].
  - ST (structural): mdu_op_id_i && pending == MDU_MAX_PENDING.
- stall = LU | BR | SB | WAW | ST. Then pc_en_o = if_id_en_o = !stall and id_ex_flush_o = stall.
- Scoreboard update at posedge clk:
  - mdu_issue_i with rd != 0 sets busy[rd] and increments pending.
  - mdu_wb_i with rd != 0 clears busy[rd] and decrements pending.
  - Issue with rd == 0 still counts toward pending, but never sets busy[0].
- Clears are not bypassed: a register cleared by writeback is visible as free the next cycle.
- Simultaneous issue and writeback: pending is unchanged. On the same rd, set wins and busy stays 1.
- Overflow: issue when pending == MAX with no wb sets err_o and leaves pending unchanged.
- Underflow: wb when pending == 0 sets err_o; pending stays 0.
- err_o is cleared only by rst.
- Stalling does not block scoreboard updates; EX/MEM/WB keep draining.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles_o and lu_stalls_o (CNT_W each).
  - stall_cycles_o increments every cycle stall = 1.
  - lu_stalls_o increments every cycle LU = 1.
  - Both saturate at all-ones and reset to 0.
- Not defined: the ports are absent and the logic is removed.

Test Plan:
- Load-use: EX load to x5, ID uses rs1 = x5 -> pc_en_o = 0, id_ex_flush_o = 1 for 1 cycle. Same with rs1 = x0 -> no stall.
- Branch: branch_id_i with rs2 = x7; EX ALU writes x7 -> stall. Next cycle x7 is in MEM as non-load -> no stall. MEM load to x7 -> stall.
- Scoreboard: issue div to x10 -> cycle 0 ID uses x10 via bypass -> stall held until the cycle after mdu_wb_i for x10, then released.
- Full: MAX = 2, issue x3 and x4, ID mdu_op -> stall. Wb x3 -> released next cycle, mdu_pending_o = 1.
- Simultaneous issue x8 and wb x8 with pending = 1 -> pending stays 1, busy[8] = 1. Wb with pending = 0 -> err_o = 1 until rst.
- Reset mid-operation: pending = 2, busy x3/x4, assert rst for 1 cycle -> pending = 0, busy clear, ID using x3 does not stall.
